// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_sub_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_subtractor_fs.sv
// One-bit full subtractor cell: d = x - y - bi, with borrow-out bo.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = x ^ y ^ bi;
  assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor, LSB first, one bit per clock with start/busy/done.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh, d_sh;
  logic [CNT_W-1:0] cnt;
  logic             borrow;
  logic             d, bo;

  full_subtractor u_fs (
    .x  (a_sh[0]),
    .y  (b_sh[0]),
    .bi (borrow),
    .d  (d),
    .bo (bo)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (cnt == LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Status flags decode straight from the state flop, so no input reaches them.
  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      d_sh   <= '0;
      cnt    <= '0;
      borrow <= 1'b0;
      diff   <= '0;
      bout   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          a_sh   <= a;
          b_sh   <= b;
          borrow <= bin;
          cnt    <= '0;
          d_sh   <= '0;
        end
        RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          d_sh   <= {d, d_sh[WIDTH-1:1]};
          borrow <= bo;
          cnt    <= cnt + CNT_W'(1);
          // Last bit: publish the completed word together with the final borrow.
          if (cnt == LAST) begin
            diff <= {d, d_sh[WIDTH-1:1]};
            bout <= bo;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench: directed cases plus a random sweep against an arithmetic model.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a, b;
  logic         bin;
  logic         busy, done;
  logic [W-1:0] diff;
  logic         bout;

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  always @(posedge clk) if (done) done_cnt++;

  always @(negedge clk) if (rst_n === 1'b1) chk("busy_done_excl", int'(busy & done), 0);

  // poke >= 0: re-assert start with junk operands after that many RUN edges.
  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tbin,
                       input int poke);
    int lat, d0, x;
    logic [W-1:0] ed;
    logic eb;
    x  = int'(ta) - int'(tb) - int'(tbin);
    ed = x[W-1:0];
    eb = int'(ta) < int'(tb) + int'(tbin);
    @(negedge clk);
    a = ta; b = tb; bin = tbin; start = 1'b1;
    d0 = done_cnt;
    @(posedge clk);
    lat = 0;
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
    chk("busy_after_accept", int'(busy), 1);
    while (!done && lat < W + 4) begin
      if (lat == poke) begin start = 1'b1; a = 1; b = 1; end
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    start = 1'b0;
    chk("latency", lat, W);
    chk("diff", int'(diff), int'(ed));
    chk("bout", int'(bout), int'(eb));
    @(negedge clk);
    chk("diff_hold", int'(diff), int'(ed));
    chk("bout_hold", int'(bout), int'(eb));
    chk("done_one_cycle", int'(done), 0);
    chk("done_pulses", done_cnt - d0, 1);
  endtask

  initial begin
    int d0;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_diff", int'(diff), 0);
    chk("rst_bout", int'(bout), 0);
    rst_n = 1'b1;

    do_op(8'd100, 8'd100, 1'b1, -1);
    do_op(8'd200, 8'd20,  1'b0, -1);
    do_op(8'd20,  8'd200, 1'b0, -1);
    do_op(8'd0,   8'd255, 1'b1, -1);
    do_op(8'd117, 8'd57,  1'b1, -1);
    do_op(8'd72,  8'd56,  1'b0, 3);

    // Abort mid-run with reset.
    @(negedge clk);
    a = 8'd222; b = 8'd242; bin = 1'b1; start = 1'b1;
    d0 = done_cnt;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_diff", int'(diff), 0);
    chk("abort_bout", int'(bout), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (W + 2) @(negedge clk);
    chk("abort_no_done", done_cnt - d0, 0);
    chk("abort_idle", int'(busy), 0);
    do_op(8'd222, 8'd242, 1'b1, -1);

    for (int i = 0; i < 1000; i++)
      do_op(W'($urandom), W'($urandom), 1'($urandom), -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial unsigned subtractor that computes `diff = a - b - bin` over `WIDTH` clock cycles, one bit per cycle starting at the LSB. It produces a borrow-out flag. It is the inverse companion to the combinational eight-bit adder: it takes operands in the adder's format, and a result from it recovers an adder operand. It uses a start/busy/done handshake, so it can sit behind a controller or testbench driving one operation at a time.

## Interface
Parameters:
- `WIDTH`, default 8: operand and result width in bits, minimum 2.

Ports:
- `clk`, input, 1: system clock, rising-edge active.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `start`, input, 1: request to begin an operation; sampled only in IDLE.
- `a`, input, `WIDTH`: minuend; captured on the accepting edge.
- `b`, input, `WIDTH`: subtrahend; captured on the accepting edge.
- `bin`, input, 1: borrow-in; captured on the accepting edge.
- `busy`, output, 1: high while bits are being processed (RUN).
- `done`, output, 1: one-cycle pulse; `diff` and `bout` are valid and updated.
- `diff`, output, `WIDTH`: result `(a - b - bin) mod 2^WIDTH`; held until the next completion.
- `bout`, output, 1: borrow-out; 1 iff `a < b + bin` (unsigned).

## Operation
- States:
  - IDLE: wait for `start`.
  - RUN: `busy`=1; process one bit per cycle.
  - DONE: `done`=1 for exactly one cycle.
- IDLE to RUN on a rising edge with `start`=1. That edge:
  - latches `a` and `b` into shift registers `a_sh` and `b_sh`;
  - latches `bin` into the borrow flip-flop;
  - clears the bit counter `cnt` to 0 and clears `d_sh`.
- RUN, on each edge:
  - Full-subtract `a_sh[0]`, `b_sh[0]` and `borrow`:
    - `d = x ^ y ^ bi`
    - `bo = (~x & y) | (~(x ^ y) & bi)`
  - Shift `a_sh` and `b_sh` right by one.
  - Shift `d` into the MSB of `d_sh` (right shift).
  - Load `bo` into `borrow`; increment `cnt`.
- RUN to DONE on the edge where `cnt == WIDTH-1`. That edge also loads:
  - `diff` with the fully shifted result;
  - `bout` with the final `bo`.
- DONE to IDLE unconditionally on the next edge. `start` is ignored in DONE.
- `start` is ignored in RUN and DONE. Captured operands are never disturbed mid-operation.
- Inputs `a`, `b` and `bin` are don't-care except on the accepting edge.
- `diff` and `bout` change only on the RUN-to-DONE edge (or on reset). Between operations they hold the last result.
- Reset mid-operation aborts immediately. The block returns to IDLE and all outputs go to their reset values; no `done` pulse is produced for the aborted operation.
- `cnt` width is `$clog2(WIDTH)`. There is no wrap-around inside an operation, because the count terminates at `WIDTH-1`.

## Timing
- Reset values:
  - state = IDLE
  - `busy` = 0, `done` = 0
  - `diff` = 0, `bout` = 0
  - internal registers = 0
- Latency: `start` accepted at edge E0.
  - `busy` is 1 from after E0 through edge E`WIDTH`.
  - `done` is 1 in the cycle after edge E`WIDTH`: a WIDTH-cycle latency, or 8 cycles at default.
- Throughput: one operation per `WIDTH+2` cycles. The earliest next accept is the edge after the DONE cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- `busy` and `done` are never high simultaneously.

## Structure
- Package `serial_sub_pkg` holds:
  - the state enum (IDLE, RUN, DONE);
  - the `DEFAULT_WIDTH` = 8 constant.
- Sub-module `full_subtractor` holds the one-bit combinational cell:
  - inputs x, y, bi;
  - outputs d, bo;
  - instantiated once and reused across cycles.
- The top level holds the FSM, the counter, the three shift registers, and the output registers.

## Test plan
- Reset, then `a`=100, `b`=100, `bin`=1, pulse `start` → `done` pulses 8 cycles after accept, with `diff`=255 and `bout`=1.
- `a`=200, `b`=20, `bin`=0 → `diff`=180, `bout`=0. Then `a`=20, `b`=200, `bin`=0 → `diff`=76, `bout`=1.
- `a`=0, `b`=255, `bin`=1 → `diff`=0, `bout`=1. Then `a`=117, `b`=57, `bin`=1 → `diff`=59, `bout`=0.
- Accept `a`=72, `b`=56. Assert `start` with `a`=1, `b`=1 at cycle 3 of RUN → `start` is ignored; result is `diff`=16, `bout`=0; exactly one `done` pulse.
- Accept `a`=222, `b`=242, `bin`=1, then drop `rst_n` for one cycle at RUN cycle 4 → outputs are 0 and the block is in IDLE with no `done` pulse. A fresh start with the same operands yields `diff`=235, `bout`=1.
- Random sweep of 1000 operand/`bin` triples checked against `(a-b-bin)` mod 256 and the `a < b+bin` reference, with `busy`/`done` exclusivity asserted every cycle.
